// File: rtl/mac_req_arbiter.sv
// rtl/mac_req_arbiter.sv - round-robin arbiter sharing one a*b+c datapath among N_REQ requesters
// Optional feature macro: MAC_TIMEOUT_EN (WAIT-state timeout with error response)
module mac_req_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  input  logic [N_REQ*DW-1:0] req_c,
  output logic [N_REQ-1:0]    resp_valid,
  input  logic [N_REQ-1:0]    resp_ready,
  output logic [DW-1:0]       resp_data,
  output logic                resp_err,
  output logic                mac_validi,
  output logic [DW-1:0]       mac_data_in,
  input  logic                mac_valido,
  input  logic [DW-1:0]       mac_data_out,
  output logic                busy,
  output logic                stray_valido
);

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("mac_req_arbiter: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, SEND_C, WAIT, RESP} state_t;

  state_t           state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    gnt_reg;
  logic [PW-1:0]    gnt_idx;
  logic             gnt_found;
  logic [PW:0]      cand;
  logic [DW-1:0]    sel_a;
  logic [DW-1:0]    sel_b;
  logic [DW-1:0]    sel_c;
  logic [DW-1:0]    op_b;
  logic [DW-1:0]    op_c;
  logic [N_REQ-1:0] gnt_onehot;
  logic [PW-1:0]    next_ptr;

`ifdef MAC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
`else
  assign resp_err = 1'b0;
`endif

  assign gnt_onehot = N_REQ'(1) << gnt_reg;
  assign next_ptr   = (gnt_reg == PW'(N_REQ - 1)) ? '0 : gnt_reg + PW'(1);

  // Round-robin search: first asserted request at or after rr_ptr, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
      if (!gnt_found && req_valid[cand[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PW-1:0];
      end
    end
  end

  // Accept pulse goes only to the winner, and only while IDLE
  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  // Operand mux for the current winner
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_idx == PW'(k)) begin
        sel_a = req_a[k*DW +: DW];
        sel_b = req_b[k*DW +: DW];
        sel_c = req_c[k*DW +: DW];
      end
    end
  end

  // Main controller: burst a/b/c, wait for the result, hold the response until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gnt_reg      <= '0;
      op_b         <= '0;
      op_c         <= '0;
      mac_validi   <= 1'b0;
      mac_data_in  <= '0;
      resp_valid   <= '0;
      resp_data    <= '0;
      busy         <= 1'b0;
      stray_valido <= 1'b0;
`ifdef MAC_TIMEOUT_EN
      resp_err     <= 1'b0;
      tmo_cnt      <= '0;
`endif
    end else begin
      // Any result strobe outside WAIT is flagged and otherwise dropped
      stray_valido <= mac_valido && (state != WAIT);
      case (state)
        IDLE: begin
          if (gnt_found) begin
            gnt_reg     <= gnt_idx;
            op_b        <= sel_b;
            op_c        <= sel_c;
            mac_validi  <= 1'b1;
            mac_data_in <= sel_a;
            busy        <= 1'b1;
            state       <= SEND_A;
          end
        end
        SEND_A: begin
          mac_data_in <= op_b;
          state       <= SEND_B;
        end
        SEND_B: begin
          mac_data_in <= op_c;
          state       <= SEND_C;
        end
        SEND_C: begin
          mac_validi  <= 1'b0;
          mac_data_in <= '0;
`ifdef MAC_TIMEOUT_EN
          tmo_cnt     <= '0;
`endif
          state       <= WAIT;
        end
        WAIT: begin
          if (mac_valido) begin
            resp_valid <= gnt_onehot;
            resp_data  <= mac_data_out;
`ifdef MAC_TIMEOUT_EN
            resp_err   <= 1'b0;
`endif
            state      <= RESP;
          end
`ifdef MAC_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            resp_valid <= gnt_onehot;
            resp_data  <= '0;
            resp_err   <= 1'b1;
            state      <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end
        RESP: begin
          if (resp_ready[gnt_reg]) begin
            resp_valid <= '0;
            resp_data  <= '0;
`ifdef MAC_TIMEOUT_EN
            resp_err   <= 1'b0;
`endif
            busy       <= 1'b0;
            rr_ptr     <= next_ptr;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_req_arbiter.sv
// tb/tb_mac_req_arbiter.sv - directed self-checking bench for mac_req_arbiter
module tb_mac_req_arbiter;

  localparam int N_REQ       = 4;
  localparam int DW          = 32;
  localparam int TIMEOUT_CYC = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*DW-1:0] req_a = '0;
  logic [N_REQ*DW-1:0] req_b = '0;
  logic [N_REQ*DW-1:0] req_c = '0;
  logic [N_REQ-1:0]    resp_valid;
  logic [N_REQ-1:0]    resp_ready = '1;
  logic [DW-1:0]       resp_data;
  logic                resp_err;
  logic                mac_validi;
  logic [DW-1:0]       mac_data_in;
  logic                mac_valido;
  logic [DW-1:0]       mac_data_out;
  logic                busy;
  logic                stray_valido;

  always #5 clk = ~clk;

  mac_req_arbiter #(.N_REQ(N_REQ), .DW(DW), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .mac_validi(mac_validi), .mac_data_in(mac_data_in),
    .mac_valido(mac_valido), .mac_data_out(mac_data_out),
    .busy(busy), .stray_valido(stray_valido)
  );

  // Datapath model: a burst is framed by mac_validi, result one cycle after c
  logic [1:0]    beat = '0;
  logic [DW-1:0] ma = '0;
  logic [DW-1:0] mb = '0;
  logic [DW-1:0] model_out = '0;
  logic          model_vo = 1'b0;
  logic          force_vo = 1'b0;
  logic          model_silent = 1'b0;

  always @(posedge clk) begin
    model_vo <= 1'b0;
    if (mac_validi) begin
      case (beat)
        2'd0: ma <= mac_data_in;
        2'd1: mb <= mac_data_in;
        default: begin
          model_out <= ma * mb + mac_data_in;
          model_vo  <= !model_silent;
        end
      endcase
      beat <= (beat == 2'd2) ? 2'd0 : beat + 2'd1;
    end else begin
      beat <= 2'd0;
    end
  end

  assign mac_valido   = model_vo | force_vo;
  assign mac_data_out = model_out;

  // Longest run of consecutive mac_validi cycles
  int run_len = 0;
  int max_run = 0;
  always @(posedge clk) begin
    if (mac_validi) begin
      run_len <= run_len + 1;
      if (run_len + 1 > max_run) max_run <= run_len + 1;
    end else begin
      run_len <= 0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_ops(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_c[i*DW +: DW] = c;
  endtask

  task automatic wait_resp(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (resp_valid != '0) seen = 1'b1;
      else step();
    end
  endtask

  int exp_res[4] = '{2, 5, 8, 11};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int wcnt;

    // Reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_validi", mac_validi, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_stray", stray_valido, 0);
    check("rst_resp_data", resp_data, 0);

    // Single request, 3*4+5
    set_ops(0, 3, 4, 5);
    req_valid = 4'b0001;
    #1;
    check("t1_req_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    check("t1_a_valid", mac_validi, 1);
    check("t1_a_data", mac_data_in, 3);
    check("t1_busy", busy, 1);
    check("t1_ready_low", req_ready, 0);
    step();
    check("t1_b_data", mac_data_in, 4);
    step();
    check("t1_c_data", mac_data_in, 5);
    check("t1_c_valid", mac_validi, 1);
    step();
    check("t1_wait_valid", mac_validi, 0);
    check("t1_wait_data", mac_data_in, 0);
    step();
    check("t1_resp_valid", resp_valid, 4'b0001);
    check("t1_resp_data", resp_data, 17);
    check("t1_resp_err", resp_err, 0);
    step();
    check("t1_retired", resp_valid, 0);
    check("t1_idle", busy, 0);

    // All requesters asserting: order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_ops(i, i + 1, 2, i);
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_resp(seen);
      check("t2_seen", seen, 1);
      check("t2_order", resp_valid, 4'b0001 << (t % 4));
      check("t2_result", resp_data, exp_res[t % 4]);
      step();
    end
    req_valid = '0;

    // Backpressure on requester 1
    set_ops(0, 3, 4, 5);
    set_ops(1, 6, 7, 1);
    step();
    req_valid  = 4'b0010;
    resp_ready = 4'b0001;
    step();
    req_valid = 4'b0001;
    wait_resp(seen);
    check("t3_seen", seen, 1);
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_valid", resp_valid, 4'b0010);
      check("t3_hold_data", resp_data, 43);
      check("t3_no_accept", req_ready, 0);
      step();
    end
    check("t3_cycle6_valid", resp_valid, 4'b0010);
    resp_ready = 4'b0011;
    step();
    check("t3_retired", resp_valid, 0);
    check("t3_wrap_grant", req_ready, 4'b0001);
    step();
    req_valid  = '0;
    resp_ready = 4'b1111;
    wait_resp(seen);
    check("t3b_seen", seen, 1);
    check("t3b_valid", resp_valid, 4'b0001);
    check("t3b_data", resp_data, 17);
    step();

    // Reset during SEND_B
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    check("t4_sendb_valid", mac_validi, 1);
    check("t4_sendb_data", mac_data_in, 2);
    rst = 1'b1;
    step();
    check("t4_rst_validi", mac_validi, 0);
    check("t4_rst_data", mac_data_in, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_resp", resp_valid, 0);
    check("t4_rst_stray", stray_valido, 0);
    rst = 1'b0;
    force_vo = 1'b1;
    step();
    force_vo = 1'b0;
    check("t4_late_stray", stray_valido, 1);
    check("t4_late_no_resp", resp_valid, 0);
    check("t4_late_idle", busy, 0);
    step();
    check("t4_still_no_resp", resp_valid, 0);
    req_valid = 4'b0101;
    #1;
    check("t4_grant0", req_ready, 4'b0001);
    step();
    req_valid = '0;
    wait_resp(seen);
    check("t4_seen", seen, 1);
    check("t4_valid", resp_valid, 4'b0001);
    check("t4_data", resp_data, 17);
    step();

    // Stray valido in IDLE and SEND_A
    force_vo  = 1'b1;
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    check("t5_stray_idle", stray_valido, 1);
    check("t5_busy", busy, 1);
    step();
    check("t5_stray_senda", stray_valido, 1);
    force_vo = 1'b0;
    step();
    check("t5_stray_off", stray_valido, 0);
    wait_resp(seen);
    check("t5_seen", seen, 1);
    check("t5_valid", resp_valid, 4'b0010);
    check("t5_data", resp_data, 43);
    step();

`ifdef MAC_TIMEOUT_EN
    // Silent datapath: timeout after TIMEOUT_CYC WAIT cycles
    model_silent = 1'b1;
    resp_ready   = 4'b1011;
    req_valid    = 4'b0100;
    step();
    req_valid = '0;
    step();
    step();
    step();
    check("t6_in_wait", mac_validi, 0);
    wcnt = 0;
    while (resp_valid == '0 && wcnt < 40) begin
      step();
      wcnt++;
    end
    check("t6_wait_cycles", wcnt, TIMEOUT_CYC);
    check("t6_valid", resp_valid, 4'b0100);
    check("t6_err", resp_err, 1);
    check("t6_data", resp_data, 0);
    force_vo = 1'b1;
    step();
    force_vo = 1'b0;
    check("t6_late_stray", stray_valido, 1);
    check("t6_hold_err", resp_err, 1);
    check("t6_hold_valid", resp_valid, 4'b0100);
    resp_ready = 4'b1111;
    step();
    check("t6_retired", resp_valid, 0);
    check("t6_err_clear", resp_err, 0);
    model_silent = 1'b0;
`endif

    step();
    check("max_validi_run", max_run, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
